// File: rtl/param_icache.sv
// -----------------------------------------------------------------------------
// param_icache
// Direct-mapped, read-only instruction cache. It has NUM_LINES lines of
// WORDS_PER_LINE 32-bit words each. A miss fetches one whole line from the
// backing memory, then returns the requested word from that new line.
//
// Ports
//   clk, reset          : sole clock and synchronous active-high reset
//   cpu_req, cpu_addr   : fetch request and byte address, both sampled in IDLE
//   flush               : invalidate all lines, sampled in IDLE
//   instruction, hit    : fetched word and its one-cycle valid pulse
//   busy                : high while a line fill is outstanding
//   mem_req, mem_addr   : line-fill request and line-aligned fill address
//   mem_valid, mem_data : fill handshake and the full fill line (word k in bits
//                         [32k+31:32k])
//   hit_count,
//   miss_count          : wrapping 16-bit event counters
// -----------------------------------------------------------------------------
module param_icache #(
    parameter int ADDR_W         = 32,
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cpu_req,
    input  logic [ADDR_W-1:0]           cpu_addr,
    input  logic                        flush,
    output logic [31:0]                 instruction,
    output logic                        hit,
    output logic                        busy,
    output logic                        mem_req,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic                        mem_valid,
    input  logic [32*WORDS_PER_LINE-1:0] mem_data,
    output logic [15:0]                 hit_count,
    output logic [15:0]                 miss_count
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int LSB_IDX = OFF_W + 2;
    localparam int LSB_TAG = LSB_IDX + IDX_W;
    localparam int TAG_W   = ADDR_W - LSB_TAG;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];

    // The word offset of the outstanding miss. mem_addr keeps only the line
    // address, so the offset must be held separately for the response.
    logic [OFF_W-1:0]     req_off_q;

    // Split the incoming address into offset, index and tag.
    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;

    assign cpu_off = cpu_addr[LSB_IDX-1:2];
    assign cpu_idx = cpu_addr[LSB_TAG-1:LSB_IDX];
    assign cpu_tag = cpu_addr[ADDR_W-1:LSB_TAG];

    // A fill always targets the line named by the latched mem_addr.
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    assign fill_idx = mem_addr[LSB_TAG-1:LSB_IDX];
    assign fill_tag = mem_addr[ADDR_W-1:LSB_TAG];

    // The byte-select bits of the address play no part in a word fetch.
    logic unused_byte_sel;
    assign unused_byte_sel = ^cpu_addr[1:0];

    logic lookup_hit;
    logic accept_hit;
    logic accept_miss;
    logic fill_done;

    assign lookup_hit = valid_q[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

    // A flush in the same cycle as a request empties the cache first. That
    // request is therefore always a miss, even when its line was resident.
    always_comb begin
        state_d     = state_q;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (!flush && lookup_hit) begin
                        accept_hit = 1'b1;
                    end else begin
                        accept_miss = 1'b1;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                if (mem_valid) begin
                    fill_done = 1'b1;
                    state_d   = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req = (state_q == FILL);
    assign busy    = (state_q == FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            hit         <= 1'b0;
            instruction <= '0;
            mem_addr    <= '0;
            req_off_q   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            state_q <= state_d;
            hit     <= accept_hit | fill_done;

            if (state_q == IDLE && flush) begin
                valid_q <= '0;
            end
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
                instruction       <= mem_data[{req_off_q, 5'd0} +: 32];
            end

            if (accept_hit) begin
                instruction <= data_arr[cpu_idx][cpu_off];
                hit_count   <= hit_count + 16'd1;
            end

            if (accept_miss) begin
                mem_addr   <= {cpu_addr[ADDR_W-1:LSB_IDX], {LSB_IDX{1'b0}}};
                req_off_q  <= cpu_off;
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    // Tag and data storage carry no reset, because the valid bits decide
    // whether a line is used. A fill aborted by reset leaves an entry that is
    // marked invalid, so its contents do not matter.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[fill_idx] <= fill_tag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                data_arr[fill_idx][w] <= mem_data[32*w +: 32];
            end
        end
    end

endmodule

// File: tb/tb_param_icache.sv
// -----------------------------------------------------------------------------
// tb_param_icache
// Self-checking bench for param_icache with its default parameters.
// The reference model keeps, for each cache index, the resident line's byte
// address and its words. Hits, misses and the expected words all come from
// that model using plain address arithmetic.
// -----------------------------------------------------------------------------
module tb_param_icache;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [31:0]  cpu_addr;
    logic         flush;
    logic [31:0]  instruction;
    logic         hit;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic [127:0] mem_data;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    param_icache #(
        .ADDR_W(32),
        .NUM_LINES(8),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_addr(cpu_addr),
        .flush(flush),
        .instruction(instruction),
        .hit(hit),
        .busy(busy),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_valid(mem_valid),
        .mem_data(mem_data),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model state.
    bit          m_valid [8];
    logic [31:0] m_line  [8];
    logic [31:0] m_data  [8][4];
    logic [15:0] exp_hits;
    logic [15:0] exp_misses;
    logic [31:0] last_instr;
    logic [31:0] next_fill [4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 0;
    endtask

    task automatic randomize_fill();
        for (int k = 0; k < 4; k++) next_fill[k] = $urandom;
    endtask

    // Called at a negedge. Applies reset for one edge and checks every
    // control output against its reset value.
    task automatic do_reset();
        reset    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 32'h40;
        flush    = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        cpu_req = 1'b0;
        model_clear();
        exp_hits   = '0;
        exp_misses = '0;
        last_instr = '0;
        check("rst_hit",   hit, 0);
        check("rst_busy",  busy, 0);
        check("rst_mreq",  mem_req, 0);
        check("rst_maddr", mem_addr, 0);
        check("rst_instr", instruction, 0);
        check("rst_hcnt",  hit_count, 0);
        check("rst_mcnt",  miss_count, 0);
    endtask

    // Called at a negedge and returns at a negedge with the DUT back in IDLE.
    // On a miss, the line is returned after wait_cycles cycles in which
    // random request/flush traffic must be ignored. The line data comes
    // from next_fill.
    task automatic fetch(input logic [31:0] addr, input bit do_flush, input int wait_cycles);
        int          idx;
        int          off;
        logic [31:0] line;
        bit          exp_hit;
        line = addr & ~32'hF;
        idx  = (addr >> 4) & 7;
        off  = (addr >> 2) & 3;
        cpu_req  = 1'b1;
        cpu_addr = addr;
        flush    = do_flush;
        if (do_flush) model_clear();
        exp_hit = m_valid[idx] && (m_line[idx] == line);
        @(negedge clk);
        cpu_req  = 1'b0;
        flush    = 1'b0;
        cpu_addr = $urandom;
        if (exp_hit) begin
            exp_hits   = exp_hits + 16'd1;
            last_instr = m_data[idx][off];
            check("hit_hit",   hit, 1);
            check("hit_instr", instruction, last_instr);
            check("hit_busy",  busy, 0);
            check("hit_mreq",  mem_req, 0);
            check("hit_hcnt",  hit_count, exp_hits);
        end else begin
            exp_misses = exp_misses + 16'd1;
            check("miss_hit",   hit, 0);
            check("miss_busy",  busy, 1);
            check("miss_mreq",  mem_req, 1);
            check("miss_maddr", mem_addr, line);
            check("miss_mcnt",  miss_count, exp_misses);
            for (int k = 0; k < wait_cycles; k++) begin
                cpu_req  = 1'($urandom);
                cpu_addr = $urandom;
                flush    = 1'($urandom);
                @(negedge clk);
                check("fill_mreq",  mem_req, 1);
                check("fill_busy",  busy, 1);
                check("fill_maddr", mem_addr, line);
                check("fill_hit",   hit, 0);
            end
            cpu_req   = 1'($urandom);
            cpu_addr  = $urandom;
            flush     = 1'($urandom);
            mem_valid = 1'b1;
            mem_data  = {next_fill[3], next_fill[2], next_fill[1], next_fill[0]};
            m_valid[idx] = 1;
            m_line[idx]  = line;
            for (int k = 0; k < 4; k++) m_data[idx][k] = next_fill[k];
            last_instr = next_fill[off];
            @(negedge clk);
            mem_valid = 1'b0;
            mem_data  = {$urandom, $urandom, $urandom, $urandom};
            // These inputs arrive while the DUT is in RESPOND, so they must be ignored.
            cpu_req   = 1'($urandom);
            cpu_addr  = $urandom;
            flush     = 1'($urandom);
            check("resp_hit",   hit, 1);
            check("resp_instr", instruction, last_instr);
            check("resp_busy",  busy, 0);
            check("resp_mreq",  mem_req, 0);
            check("resp_mcnt",  miss_count, exp_misses);
            @(negedge clk);
            cpu_req = 1'b0;
            flush   = 1'b0;
        end
        @(negedge clk);
        check("idle_hit",   hit, 0);
        check("idle_instr", instruction, last_instr);
        check("idle_hcnt",  hit_count, exp_hits);
        check("idle_mcnt",  miss_count, exp_misses);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        flush     = 1'b0;
        mem_valid = 1'b0;
        mem_data  = '0;
        @(negedge clk);
        do_reset();

        // Cold miss on 0x40 with the known fill pattern.
        next_fill[0] = 32'h11111111;
        next_fill[1] = 32'h22222222;
        next_fill[2] = 32'h33333333;
        next_fill[3] = 32'h44444444;
        fetch(32'h40, 0, 2);
        check("dir_instr_40", last_instr, 32'h11111111);

        // Hit on word 2 of the same line.
        fetch(32'h48, 0, 0);
        check("dir_instr_48", instruction, 32'h33333333);

        // A conflicting tag at index 4 evicts 0x40.
        randomize_fill();
        fetch(32'hC0, 0, 3);
        randomize_fill();
        fetch(32'h40, 0, 1);
        check("dir_conflict_mcnt", miss_count, 16'd3);

        // Long fill wait with cpu traffic toggling throughout.
        randomize_fill();
        fetch(32'h104, 0, 10);

        // Flush together with a request to a resident line gives a miss.
        randomize_fill();
        fetch(32'h48, 1, 2);
        check("dir_flush_mcnt", miss_count, 16'd5);

        // Reset asserted mid-fill, with mem_valid in the same cycle.
        cpu_req  = 1'b1;
        cpu_addr = 32'h80;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("mid_mreq_pre", mem_req, 1);
        reset     = 1'b1;
        mem_valid = 1'b1;
        mem_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        reset     = 1'b0;
        mem_valid = 1'b0;
        model_clear();
        exp_hits   = '0;
        exp_misses = '0;
        last_instr = '0;
        check("mid_mreq", mem_req, 0);
        check("mid_busy", busy, 0);
        check("mid_hit",  hit, 0);
        check("mid_mcnt", miss_count, 0);
        @(negedge clk);
        check("mid_hit2", hit, 0);
        randomize_fill();
        fetch(32'h40, 0, 1);
        check("mid_refetch_mcnt", miss_count, 16'd1);

        // Randomized traffic over a small address set, so that hits,
        // conflict misses and flushes all occur.
        for (int it = 0; it < 300; it++) begin
            a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            randomize_fill();
            fetch(a, ($urandom_range(0, 15) == 0), $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_icache.md
PARAM_ICACHE -- requirements
Module: param_icache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-002 SHALL have parameter NUM_LINES, default 8: direct-mapped line count, power of 2, >=2.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4: 32-bit words per line, power of 2, >=2.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cpu_req  input  1  fetch request, sampled only in IDLE.
REQ-007 SHALL have port cpu_addr  input  ADDR_W  fetch byte address; bits[1:0] ignored.
REQ-008 SHALL have port flush  input  1  invalidate all lines, sampled only in IDLE.
REQ-009 SHALL have port instruction  output  32  fetched word, valid when hit=1.
REQ-010 SHALL have port hit  output  1  one-cycle pulse: instruction valid for the accepted request.
REQ-011 SHALL have port busy  output  1  high while a miss is in progress.
REQ-012 SHALL have port mem_req  output  1  line-fill request, held until mem_valid.
REQ-013 SHALL have port mem_addr  output  ADDR_W  line-aligned fill address (offset bits zero).
REQ-014 SHALL have port mem_valid  input  1  fill data present; sampled only while mem_req=1.
REQ-015 SHALL have port mem_data  input  32*WORDS_PER_LINE  fill line; word k in bits[32k+31:32k].
REQ-016 SHALL have ports hit_count and miss_count  output  16  wrapping event counters.

Function
REQ-017 SHALL split the address as: word offset = addr[OFF+1:2] with OFF = log2(WORDS_PER_LINE); index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-018 SHALL store per line one valid bit, the tag, and WORDS_PER_LINE data words.
REQ-019 SHALL implement FSM states IDLE, FILL, RESPOND.
REQ-020 IDLE: on cpu_req with valid and matching tag, SHALL assert hit=1 with the selected word on instruction in the next cycle, stay in IDLE, and increment hit_count.
REQ-021 IDLE: on cpu_req miss, SHALL latch cpu_addr, increment miss_count, and enter FILL; mem_req=1 and busy=1 from the next cycle.
REQ-022 FILL: SHALL hold mem_req=1 with a stable mem_addr for any number of cycles until mem_valid=1.
REQ-023 On mem_valid=1 in FILL, SHALL write the line and set valid and tag, then enter RESPOND; mem_req SHALL drop the following cycle.
REQ-024 RESPOND: SHALL assert hit=1 with the requested word from the new line for exactly one cycle, deassert busy, and return to IDLE.
REQ-025 Miss latency SHALL be: request cycle + fill wait + 1 cycle to hit.
REQ-026 cpu_req and flush SHALL be ignored in FILL and RESPOND; cpu_addr changes there SHALL have no effect.
REQ-027 flush in IDLE SHALL clear every valid bit in one cycle; data and tags are don't-care.
REQ-028 flush and cpu_req in the same IDLE cycle: the flush SHALL apply first and the request SHALL be handled as a miss.
REQ-029 A miss to an index already holding a valid line SHALL overwrite that line, with no write-back.
REQ-030 hit SHALL be 0 in every cycle not named in REQ-020/REQ-024; instruction SHALL hold its last value when hit=0.
REQ-031 Counters SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-032 reset=1 SHALL, at the next edge, force IDLE, clear all valid bits, set hit=0, busy=0, mem_req=0, mem_addr=0, instruction=0, hit_count=0, miss_count=0.
REQ-033 reset SHALL take priority over all inputs, including asserting mid-FILL; a mem_valid in the same cycle SHALL be discarded.

Verification (default parameters)
REQ-034 After reset, cpu_req addr 0x40 -> next cycle busy=1, mem_req=1, mem_addr=0x40; mem_valid with mem_data words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> one cycle later hit=1, instruction=0x11111111, miss_count=1.
REQ-035 Then cpu_req 0x48 -> next cycle hit=1, instruction=0x33333333, no mem_req, hit_count=1.
REQ-036 Then cpu_req 0xC0 (index 4, tag 1) -> miss, mem_addr=0xC0; after fill, cpu_req 0x40 -> miss again.
REQ-037 Hold mem_valid=0 for 10 cycles in FILL while toggling cpu_req/cpu_addr -> mem_req=1, busy=1, mem_addr unchanged, hit=0 throughout.
REQ-038 flush with cpu_req 0x48 after line 0x40 is filled -> miss; reset mid-FILL -> mem_req=0, busy=0 the next cycle, and a re-request of 0x40 misses.
